// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl_if
// Brief    : Start/operand/result bundle for the bit-serial adder controller.
// Revision : 1.0
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    modport master (
        output start, a, b, carryin,
        input  busy, done, sum, carryout, overflow
    );

    modport slave (
        input  start, a, b, carryin,
        output busy, done, sum, carryout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Brief    : WIDTH-bit adder built from one time-shared full-adder slice, LSB first.
// Revision : 1.0
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    serial_adder_ctrl_if.slave bus
);
    localparam int c_CNT_W = $clog2(WIDTH) + 1;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_busy;
    logic               w_done;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-2:0]   r_sum_sh;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_s;
    logic               w_cout;
    logic [WIDTH-1:0]   w_sum_nxt;
    logic               w_last;

    // The single full-adder slice shared by every bit position
    assign w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_cout = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));

    // Partial sum holds WIDTH-1 finished bits; the final edge supplies the MSB
    assign w_sum_nxt = {w_s, r_sum_sh};
    assign w_last    = (r_cnt == c_CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a_sh   <= bus.a;
                        r_b_sh   <= bus.b;
                        r_sum_sh <= '0;
                        r_carry  <= bus.carryin;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_nxt[WIDTH-1:1];
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    // Carry into the MSB is the carry flop on this last step
                    if (w_last) begin
                        r_sum  <= w_sum_nxt;
                        r_cout <= w_cout;
                        r_ovf  <= r_carry ^ w_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.sum      = r_sum;
    assign bus.carryout = r_cout;
    assign bus.overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Brief    : Directed and random checks of serial_adder_ctrl at WIDTH=8.
// Revision : 1.0
// ============================================================================
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) ab ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ab)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, carryout, sum} from plain integer arithmetic
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic       ov;
        s  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        ov = (a[7] == b[7]) && (s[7] != a[7]);
        return {ov, s};
    endfunction

    function automatic logic [9:0] result();
        return {ab.overflow, ab.carryout, ab.sum};
    endfunction

    task automatic wait_done(output int k);
        k = 0;
        while (ab.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ab.done === 1'b1) n++;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input string tag, input bit full);
        int k;
        logic [9:0] exp;
        exp = model(a, b, cin);
        ab.start = 1'b1; ab.a = a; ab.b = b; ab.carryin = cin;
        @(negedge clk);
        ab.start = 1'b0;
        if (full) chk({tag, "/busy_run"}, {31'd0, ab.busy}, 32'd1);
        wait_done(k);
        if (full) chk({tag, "/latency"}, k, 8);
        chk({tag, "/result"}, {22'd0, result()}, {22'd0, exp});
        @(negedge clk);
        if (full) begin
            chk({tag, "/done_pulse"}, {30'd0, ab.done, ab.busy}, 32'd0);
            chk({tag, "/hold"}, {22'd0, result()}, {22'd0, exp});
        end
    endtask

    logic [7:0] opa [3];
    logic [7:0] opb [3];
    logic       opc [3];

    initial begin
        int k, n, cyc, last, idx;
        ab.start = 1'b0; ab.a = '0; ab.b = '0; ab.carryin = 1'b0;

        // Reset with start held high must not launch an operation
        reset = 1'b1; ab.start = 1'b1; ab.a = 8'h11; ab.b = 8'h22;
        repeat (2) @(negedge clk);
        chk("reset/busy_done", {30'd0, ab.busy, ab.done}, 32'd0);
        chk("reset/result", {22'd0, result()}, 32'd0);
        ab.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("reset/idle", {31'd0, ab.busy}, 32'd0);

        do_op(8'h00, 8'h00, 1'b0, "zero", 1);
        do_op(8'hFF, 8'h01, 1'b0, "ff_01", 1);
        do_op(8'h7F, 8'h01, 1'b0, "7f_01", 1);
        do_op(8'hA5, 8'h5A, 1'b1, "a5_5a", 1);
        do_op(8'h7F, 8'h7F, 1'b1, "7f_7f", 1);

        // Start pulsed and operands changed mid-run are ignored
        ab.start = 1'b1; ab.a = 8'h03; ab.b = 8'h04; ab.carryin = 1'b0;
        @(negedge clk);
        ab.start = 1'b0;
        repeat (2) @(negedge clk);
        ab.start = 1'b1; ab.a = 8'hFF; ab.b = 8'hFF; ab.carryin = 1'b1;
        @(negedge clk);
        ab.start = 1'b0; ab.a = 8'h55; ab.b = 8'hAA;
        wait_done(k);
        chk("midrun/done_seen", {31'd0, ab.done}, 32'd1);
        chk("midrun/result", {22'd0, result()}, {22'd0, model(8'h03, 8'h04, 1'b0)});
        count_dones(15, n);
        chk("midrun/no_second", n, 0);
        chk("midrun/idle", {31'd0, ab.busy}, 32'd0);

        // Reset in the 4th RUN cycle discards the operation and clears results
        do_op(8'hFF, 8'h80, 1'b0, "ff_80", 1);
        ab.start = 1'b1; ab.a = 8'hFF; ab.b = 8'hFF; ab.carryin = 1'b1;
        @(negedge clk);
        ab.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort/busy_done", {30'd0, ab.busy, ab.done}, 32'd0);
        chk("abort/result", {22'd0, result()}, 32'd0);
        count_dones(15, n);
        chk("abort/no_done", n, 0);
        do_op(8'h12, 8'h34, 1'b0, "after_abort", 1);

        // Start held high: three operations, one every WIDTH+2 cycles
        opa[0] = 8'h11; opb[0] = 8'h22; opc[0] = 1'b0;
        opa[1] = 8'hF0; opb[1] = 8'h10; opc[1] = 1'b1;
        opa[2] = 8'h80; opb[2] = 8'h80; opc[2] = 1'b1;
        ab.start = 1'b1; ab.a = opa[0]; ab.b = opb[0]; ab.carryin = opc[0];
        cyc = 0; last = 0; idx = 0;
        while (idx < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ab.done === 1'b1) begin
                chk($sformatf("b2b%0d/result", idx), {22'd0, result()},
                    {22'd0, model(opa[idx], opb[idx], opc[idx])});
                if (idx > 0) chk($sformatf("b2b%0d/gap", idx), cyc - last, 10);
                last = cyc;
                idx++;
                if (idx < 3) begin
                    ab.a = opa[idx]; ab.b = opb[idx]; ab.carryin = opc[idx];
                end else begin
                    ab.start = 1'b0;
                end
            end
        end
        chk("b2b/count", idx, 3);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), "random", 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
